atcdmac300_apbslv_q: RTL

- Parametrised successor APB slave for the DMAC register file.
- Converts APB transfers into command words for the register-side command buffer and returns read data from the read-data buffer.
- Adds a registered command hold stage, so a setup phase that arrives while the command buffer is full is never lost.
- Adds a read-data timeout that returns PSLVERR, and flushes stale read data that arrives after a timeout.

---
 rtl/atcdmac300_apb_pkg.sv | 30 +++
 rtl/atcdmac300_apbslv_tmo.sv | 56 +++++
 rtl/atcdmac300_apbslv_q.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/atcdmac300_apb_pkg.sv
// Shared types and command-word layout for the DMAC APB slave.
// ATCDMAC300_APB_PSTRB_EN adds a 4-bit strobe field on top of the command.
package atcdmac300_apb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PUSH,
      S_RWAIT,
      S_DONE
   } state_t;

   localparam int CMD_DATA_LSB = 0;
   localparam int CMD_ADDR_LSB = 32;
   localparam int STRB_W       = 4;

   function automatic int cmd_wr_bit(input int addr_msb);
      return CMD_ADDR_LSB + addr_msb - 1;
   endfunction

   function automatic int cmd_w(input int addr_msb);
`ifdef ATCDMAC300_APB_PSTRB_EN
      return 1 + (addr_msb - 1) + 32 + STRB_W;
`else
      return 1 + (addr_msb - 1) + 32;
`endif
   endfunction

   localparam int CMD_WR_BIT = cmd_wr_bit(8);

endpackage

// File: rtl/atcdmac300_apbslv_tmo.sv
// Read-data timer with expiry pulse and the owed-late-data counter.
// The counter saturates at DROP_MAX; inc and dec together leave it alone.
module atcdmac300_apbslv_tmo #(
   parameter int  TIMEOUT  = 255,
   parameter int  DROP_MAX = 3,
   localparam int DW       = $clog2(DROP_MAX + 1),
   localparam int TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          run_i,
   input  logic          hit_i,
   input  logic          dec_i,
   output logic          expire_o,
   output logic [DW-1:0] drop_cnt_o
);

   localparam bit            TMO_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [DW-1:0] DMAX   = DW'(DROP_MAX);

   logic [TW-1:0] tmr_q, tmr_d;
   logic [DW-1:0] drop_q, drop_d;

   assign expire_o   = TMO_EN & run_i & ~hit_i & (tmr_q == LAST);
   assign drop_cnt_o = drop_q;

   // next timer and drop count
   always_comb begin
      tmr_d  = tmr_q;
      drop_d = drop_q;
      if (clr_i) begin
         tmr_d = '0;
      end else if (run_i && TMO_EN) begin
         tmr_d = tmr_q + TW'(1);
      end
      if (expire_o && !dec_i) begin
         if (drop_q != DMAX) drop_d = drop_q + DW'(1);
      end else if (dec_i && !expire_o && drop_q != '0) begin
         drop_d = drop_q - DW'(1);
      end
   end

   // timer and counter state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmr_q  <= '0;
         drop_q <= '0;
      end else begin
         tmr_q  <= tmr_d;
         drop_q <= drop_d;
      end
   end

endmodule

// File: rtl/atcdmac300_apbslv_q.sv
// APB slave with held command stage, read timeout and stale-data flush.
// ATCDMAC300_APB_PSTRB_EN carries pstrb in the command (zero on reads).
module atcdmac300_apbslv_q
   import atcdmac300_apb_pkg::*;
#(
   parameter int  ADDR_MSB = 8,
   parameter int  TIMEOUT  = 255,
   parameter int  DROP_MAX = 3,
   localparam int CMD_W    = cmd_w(ADDR_MSB)
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [31:0]      paddr,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [31:0]      pwdata,
   input  logic [3:0]       pstrb,
   output logic             pready,
   output logic [31:0]      prdata,
   output logic             pslverr,
   output logic             cmd_buff_wr,
   output logic [CMD_W-1:0] cmd_buff_wdata,
   input  logic             cmd_buff_full,
   output logic             rdata_buff_rd,
   input  logic [31:0]      rdata_buff_rdata,
   input  logic             rdata_buff_empty
);

   localparam int WR_BIT = cmd_wr_bit(ADDR_MSB);
   localparam int DW     = $clog2(DROP_MAX + 1);

   state_t           state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d, cmd_new;
   logic [31:0]      prdata_q, prdata_d;
   logic             err_q, err_d;
   logic             pend_q, pend_d;
   logic [DW-1:0]    drop_cnt;
   logic             flush, vpop, setup, expire;
   logic             tmr_clr, tmr_run;

`ifdef ATCDMAC300_APB_PSTRB_EN
   assign cmd_new = {(pwrite ? pstrb : 4'b0), pwrite,
                     paddr[ADDR_MSB:2], pwdata};
   logic unused_sig;
   assign unused_sig = ^{paddr[31:ADDR_MSB+1], paddr[1:0]};
`else
   assign cmd_new = {pwrite, paddr[ADDR_MSB:2], pwdata};
   logic unused_sig;
   assign unused_sig = ^{paddr[31:ADDR_MSB+1], paddr[1:0], pstrb};
`endif

   assign flush = (drop_cnt != '0) & ~rdata_buff_empty;
   assign vpop  = (state_q == S_RWAIT) & (drop_cnt == '0)
                & ~rdata_buff_empty;
   assign setup = psel & (~penable | pend_q);

   assign rdata_buff_rd  = flush | vpop;
   assign cmd_buff_wdata = cmd_q;
   assign prdata         = prdata_q;

   atcdmac300_apbslv_tmo #(
      .TIMEOUT  (TIMEOUT),
      .DROP_MAX (DROP_MAX)
   ) u_tmo (
      .clk_i      (pclk),
      .rst_ni     (presetn),
      .clr_i      (tmr_clr),
      .run_i      (tmr_run),
      .hit_i      (vpop),
      .dec_i      (flush),
      .expire_o   (expire),
      .drop_cnt_o (drop_cnt)
   );

   // next state and transfer outputs
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      prdata_d    = prdata_q;
      err_d       = err_q;
      pend_d      = 1'b0;
      cmd_buff_wr = 1'b0;
      pready      = 1'b0;
      pslverr     = 1'b0;
      tmr_clr     = 1'b0;
      tmr_run     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            pend_d = setup & flush;
            if (setup && !flush) begin
               cmd_d   = cmd_new;
               err_d   = 1'b0;
               tmr_clr = 1'b1;
               state_d = S_PUSH;
            end
         end
         S_PUSH: begin
            cmd_buff_wr = ~cmd_buff_full;
            if (!cmd_buff_full) begin
               state_d = cmd_q[WR_BIT] ? S_DONE : S_RWAIT;
            end
         end
         S_RWAIT: begin
            tmr_run = 1'b1;
            if (vpop) begin
               prdata_d = rdata_buff_rdata;
               state_d  = S_DONE;
            end else if (expire) begin
               err_d    = 1'b1;
               prdata_d = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            pready  = 1'b1;
            pslverr = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // transfer state
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q  <= S_IDLE;
         cmd_q    <= '0;
         prdata_q <= '0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         prdata_q <= prdata_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
      end
   end

endmodule
